minutos_horas: RTL and testbench

//  Downstream stage of the seconds counter: consumes its one-cycle inc_min pulse and keeps

---
 rtl/minutos_horas_if.sv | 23 ++
 rtl/minutos_horas.sv | 120 ++++++++++++
 tb/tb_minutos_horas.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/minutos_horas_if.sv
// rtl/minutos_horas_if.sv - minutes/hours stage signal bundle
// Inputs from the seconds counter and buttons, outputs to the display.
interface minutos_horas_if;
  logic       inc_min_i;
  logic       btn_mode_i;
  logic       btn_up_i;
  logic [5:0] minutos_o;
  logic [4:0] horas_o;
  logic [7:0] min_bcd_o;
  logic [7:0] hora_bcd_o;
  logic       inc_dia_o;
  logic [1:0] set_sel_o;

  modport slave (
    input  inc_min_i, btn_mode_i, btn_up_i,
    output minutos_o, horas_o, min_bcd_o, hora_bcd_o, inc_dia_o, set_sel_o
  );

  modport master (
    output inc_min_i, btn_mode_i, btn_up_i,
    input  minutos_o, horas_o, min_bcd_o, hora_bcd_o, inc_dia_o, set_sel_o
  );
endinterface

// File: rtl/minutos_horas.sv
// rtl/minutos_horas.sv - minutes/hours counter with button time-set and BCD display outputs
// Consumes the seconds stage inc_min pulse; buttons are synchronised and edge-detected here.
module minutos_horas #(
  parameter int MIN_MOD     = 60,
  parameter int HORA_MOD    = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  minutos_horas_if.slave         bus
);

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_SET_HORA = 2'b01;
  localparam logic [1:0] ST_SET_MIN  = 2'b10;

  localparam logic [5:0] MIN_MAX  = 6'(MIN_MOD - 1);
  localparam logic [4:0] HORA_MAX = 5'(HORA_MOD - 1);

  logic [SYNC_STAGES-1:0] mode_sync_q, up_sync_q;
  logic                   mode_prev_q, up_prev_q;
  logic                   mode_rise, up_rise;

  logic [1:0] state_q, state_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hora_q, hora_d;
  logic       dia_q, dia_d;
  logic [7:0] min_bcd_q, min_bcd_d;
  logic [7:0] hora_bcd_q, hora_bcd_d;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mode_sync_q <= '0;
      up_sync_q   <= '0;
      mode_prev_q <= 1'b0;
      up_prev_q   <= 1'b0;
    end else begin
      mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], bus.btn_mode_i};
      up_sync_q   <= {up_sync_q[SYNC_STAGES-2:0], bus.btn_up_i};
      mode_prev_q <= mode_sync_q[SYNC_STAGES-1];
      up_prev_q   <= up_sync_q[SYNC_STAGES-1];
    end
  end

  assign mode_rise = mode_sync_q[SYNC_STAGES-1] & ~mode_prev_q;
  assign up_rise   = up_sync_q[SYNC_STAGES-1] & ~up_prev_q;

  always_comb begin
    min_d   = min_q;
    hora_d  = hora_q;
    dia_d   = 1'b0;
    state_d = state_q;

    case (state_q)
      ST_RUN: begin
        if (bus.inc_min_i) begin
          if (min_q < MIN_MAX) begin
            min_d = min_q + 6'd1;
          end else begin
            min_d = '0;
            // Only a genuine 59 -> 0 step carries; out-of-range values just wrap.
            if (min_q == MIN_MAX) begin
              if (hora_q < HORA_MAX) begin
                hora_d = hora_q + 5'd1;
              end else begin
                hora_d = '0;
                dia_d  = (hora_q == HORA_MAX);
              end
            end
          end
        end
      end
      ST_SET_HORA: begin
        if (up_rise) hora_d = (hora_q < HORA_MAX) ? hora_q + 5'd1 : '0;
      end
      ST_SET_MIN: begin
        if (up_rise) min_d = (min_q < MIN_MAX) ? min_q + 6'd1 : '0;
      end
      default: state_d = ST_RUN;
    endcase

    // Up acts on the field of the state before this transition.
    if (mode_rise) begin
      case (state_q)
        ST_RUN:      state_d = ST_SET_HORA;
        ST_SET_HORA: state_d = ST_SET_MIN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  assign min_bcd_d  = {4'(min_q / 6'd10), 4'(min_q % 6'd10)};
  assign hora_bcd_d = {4'(hora_q / 5'd10), 4'(hora_q % 5'd10)};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_RUN;
      min_q      <= '0;
      hora_q     <= '0;
      dia_q      <= 1'b0;
      min_bcd_q  <= '0;
      hora_bcd_q <= '0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      hora_q     <= hora_d;
      dia_q      <= dia_d;
      min_bcd_q  <= min_bcd_d;
      hora_bcd_q <= hora_bcd_d;
    end
  end

  assign bus.minutos_o  = min_q;
  assign bus.horas_o    = hora_q;
  assign bus.min_bcd_o  = min_bcd_q;
  assign bus.hora_bcd_o = hora_bcd_q;
  assign bus.inc_dia_o  = dia_q;
  assign bus.set_sel_o  = state_q;

endmodule

// File: tb/tb_minutos_horas.sv
// tb/tb_minutos_horas.sv - scoreboard bench for minutos_horas
// Stimulus pushes cycle-stamped expectations; negedge monitor pops and compares.
module tb_minutos_horas;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  minutos_horas_if bus();

  minutos_horas dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [5:0] m;
    logic [4:0] h;
    logic [7:0] mb;
    logic [7:0] hb;
    logic [1:0] sel;
    int         dcnt;
  } exp_t;

  exp_t sbq[$];
  exp_t aq[$];
  event chk_now;

  int cyc      = 0;
  int n_vec    = 0;
  int n_fail   = 0;
  int dia_seen = 0;

  int em = 0, eh = 0, esel = 0, edcnt = 0;

  always @(posedge clk_i) cyc++;

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic void check(exp_t e, bit async_chk);
    int dia_got;
    dia_got = async_chk ? int'(bus.inc_dia_o) : dia_seen;
    n_vec++;
    if (bus.minutos_o !== e.m || bus.horas_o !== e.h || bus.min_bcd_o !== e.mb ||
        bus.hora_bcd_o !== e.hb || bus.set_sel_o !== e.sel || dia_got != e.dcnt) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got m=%0d h=%0d mb=%h hb=%h sel=%b dia=%0d, want m=%0d h=%0d mb=%h hb=%h sel=%b dia=%0d",
               e.tag, cyc, bus.minutos_o, bus.horas_o, bus.min_bcd_o, bus.hora_bcd_o,
               bus.set_sel_o, dia_got, e.m, e.h, e.mb, e.hb, e.sel, e.dcnt);
    end
  endfunction

  always @(negedge clk_i) begin
    if (!rstn_i) dia_seen = 0;
    else if (bus.inc_dia_o === 1'b1) dia_seen++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      if (sbq[0].cyc < cyc) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s: check for cyc %0d missed (now %0d)", sbq[0].tag, sbq[0].cyc, cyc);
      end else begin
        check(sbq[0], 1'b0);
      end
      void'(sbq.pop_front());
    end
  end

  always @(chk_now) begin
    while (aq.size() > 0) begin
      check(aq[0], 1'b1);
      void'(aq.pop_front());
    end
  end

  task automatic push(int at, string tag, int m, int h, logic [7:0] mb, logic [7:0] hb,
                      int sel, int dc);
    exp_t e;
    e.cyc = at; e.tag = tag; e.m = 6'(m); e.h = 5'(h);
    e.mb = mb; e.hb = hb; e.sel = 2'(sel); e.dcnt = dc;
    sbq.push_back(e);
  endtask

  task automatic pulse_inc(string tag);
    int c, om, oh;
    @(posedge clk_i); #1;
    c = cyc; om = em; oh = eh;
    bus.inc_min_i = 1'b1;
    if (esel == 0) begin
      if (em == 59) begin
        em = 0;
        if (eh == 23) begin eh = 0; edcnt++; end
        else eh++;
      end else begin
        em++;
      end
    end
    push(c + 1, tag, em, eh, bcd(om), bcd(oh), esel, edcnt);
    push(c + 2, tag, em, eh, bcd(em), bcd(eh), esel, edcnt);
    @(posedge clk_i); #1;
    bus.inc_min_i = 1'b0;
    repeat (2) @(posedge clk_i);
  endtask

  task automatic press(bit mb, bit ub, int hold, string tag);
    int c, om, oh, osel;
    @(posedge clk_i); #1;
    c = cyc; om = em; oh = eh; osel = esel;
    bus.btn_mode_i = mb;
    bus.btn_up_i   = ub;
    if (ub) begin
      if (esel == 1) eh = (eh + 1) % 24;
      else if (esel == 2) em = (em + 1) % 60;
    end
    if (mb) esel = (esel == 0) ? 1 : (esel == 1) ? 2 : 0;
    push(c + 2, tag, om, oh, bcd(om), bcd(oh), osel, edcnt);
    push(c + 3, tag, em, eh, bcd(om), bcd(oh), esel, edcnt);
    push(c + 4, tag, em, eh, bcd(em), bcd(eh), esel, edcnt);
    repeat (hold) @(posedge clk_i);
    #1;
    bus.btn_mode_i = 1'b0;
    bus.btn_up_i   = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    push(cyc + 1, {tag, "_held"}, em, eh, bcd(em), bcd(eh), esel, edcnt);
  endtask

  task automatic expect_hand(string tag, int m, int h, int sel, logic [7:0] mb, logic [7:0] hb);
    @(posedge clk_i); #1;
    push(cyc + 1, tag, m, h, mb, hb, sel, edcnt);
  endtask

  initial begin
    bus.inc_min_i  = 1'b0;
    bus.btn_mode_i = 1'b0;
    bus.btn_up_i   = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    push(cyc + 1, "reset", 0, 0, 8'h00, 8'h00, 0, 0);
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    push(cyc + 1, "post_reset", 0, 0, 8'h00, 8'h00, 0, 0);
    @(posedge clk_i);

    // 1: sixty minute pulses roll into hour 1
    for (int i = 0; i < 60; i++) pulse_inc("t1_inc");
    expect_hand("t1_end", 0, 1, 0, 8'h00, 8'h01);

    // 2: preset 23:59 then day rollover
    press(1'b1, 1'b0, 3, "t2_mode");
    for (int i = 0; i < 22; i++) press(1'b0, 1'b1, 3, "t2_uph");
    press(1'b1, 1'b0, 3, "t2_mode");
    for (int i = 0; i < 59; i++) press(1'b0, 1'b1, 3, "t2_upm");
    press(1'b1, 1'b0, 3, "t2_mode");
    expect_hand("t2_preset", 59, 23, 0, 8'h59, 8'h23);
    pulse_inc("t2_roll");
    expect_hand("t2_0000", 0, 0, 0, 8'h00, 8'h00);
    pulse_inc("t2_after");

    // 3: hours set with wrap; minute pulses ignored
    press(1'b1, 1'b0, 3, "t3_mode");
    for (int i = 0; i < 25; i++) press(1'b0, 1'b1, 3, "t3_uph");
    for (int i = 0; i < 10; i++) pulse_inc("t3_inc_ign");
    expect_hand("t3_end", 1, 1, 1, 8'h01, 8'h01);

    // 4: minute wrap without carry, then held up in RUN
    press(1'b1, 1'b0, 3, "t4_mode");
    for (int i = 0; i < 58; i++) press(1'b0, 1'b1, 3, "t4_upm");
    press(1'b0, 1'b1, 3, "t4_wrap");
    press(1'b1, 1'b0, 3, "t4_mode_run");
    press(1'b0, 1'b1, 50, "t4_up_run");
    expect_hand("t4_end", 0, 1, 0, 8'h00, 8'h01);

    // 5: simultaneous mode+up in SET_HORA, held long
    press(1'b1, 1'b0, 3, "t5_mode");
    press(1'b1, 1'b1, 100, "t5_both");
    expect_hand("t5_end", 0, 2, 2, 8'h00, 8'h02);

    // 6: 12:34 in SET_MIN, async reset mid-cycle
    press(1'b1, 1'b0, 3, "t6_mode");
    press(1'b1, 1'b0, 3, "t6_mode");
    for (int i = 0; i < 10; i++) press(1'b0, 1'b1, 3, "t6_uph");
    press(1'b1, 1'b0, 3, "t6_mode");
    for (int i = 0; i < 34; i++) press(1'b0, 1'b1, 3, "t6_upm");
    expect_hand("t6_1234", 34, 12, 2, 8'h34, 8'h12);
    repeat (2) @(posedge clk_i);
    #3;
    rstn_i = 1'b0;
    em = 0; eh = 0; esel = 0; edcnt = 0;
    begin
      exp_t e;
      e.cyc = cyc; e.tag = "t6_async_rst"; e.m = 6'd0; e.h = 5'd0;
      e.mb = 8'h00; e.hb = 8'h00; e.sel = 2'b00; e.dcnt = 0;
      aq.push_back(e);
    end
    #1;
    -> chk_now;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    pulse_inc("t6_resume");
    press(1'b1, 1'b0, 3, "t6_mode_resume");
    expect_hand("t6_end", 1, 0, 1, 8'h01, 8'h00);

    repeat (5) @(posedge clk_i);
    #1;
    while (sbq.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: check for cyc %0d never reached", sbq[0].tag, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete, got timeout, want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
